// File: rtl/ext_irq_pkg.sv
// Shared types and helpers for the external interrupt arbiter: FSM encoding,
// source-count ceiling and the wrap-around winner search.
package ext_irq_pkg;

  localparam int IRQ_NUM_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } irq_state_e;

  // First set bit of elig at or after ptr, wrapping modulo n; ptr=0 gives lowest-ID priority.
  function automatic logic [4:0] rr_winner(input logic [IRQ_NUM_MAX-1:0] elig,
                                           input logic [4:0]             ptr,
                                           input int unsigned            n);
    logic [4:0]  win;
    logic        found;
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < IRQ_NUM_MAX; i++) begin
      idx = (32'(ptr) + i) % n;
      if (i < n && !found && elig[idx[4:0]]) begin
        win   = idx[4:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/ext_irq_sync.sv
// Two-flop synchroniser per line plus a previous-value flop for rising-edge detect.
// Latency: sync_o lags d_i by two cycles; rise_o pulses for one cycle on a synced 0->1.
module ext_irq_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/ext_irq_arbiter.sv
// External interrupt controller: latches synced sources, arbitrates enabled pending ones,
// holds one request on valid/ready until claimed, then stays busy until the matching completion.
module ext_irq_arbiter
  import ext_irq_pkg::*;
#(
  parameter int IRQ_NUM  = 8,
  parameter int IRQ_ID_W = 3,
  parameter int RR_EN    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IRQ_NUM-1:0]  irq_src_i,
  input  logic [IRQ_NUM-1:0]  irq_en_i,
  input  logic [IRQ_NUM-1:0]  irq_edge_i,
  output logic                core_ex_trap_valid_o,
  input  logic                core_ex_trap_ready_i,
  output logic [IRQ_ID_W-1:0] core_ex_trap_id_o,
  input  logic                irq_cmpl_i,
  input  logic [IRQ_ID_W-1:0] irq_cmpl_id_i,
  output logic [IRQ_NUM-1:0]  irq_pending_o,
  output logic                irq_busy_o
);

  logic [IRQ_NUM-1:0]     src_sync;
  logic [IRQ_NUM-1:0]     src_rise;
  logic [IRQ_NUM-1:0]     pend_q;
  logic [IRQ_NUM-1:0]     set_v;
  logic [IRQ_NUM-1:0]     clr_v;
  logic [IRQ_NUM-1:0]     elig;
  logic [IRQ_NUM_MAX-1:0] elig_ext;
  logic [4:0]             ptr_sel;
  logic [4:0]             win5;
  logic [IRQ_ID_W-1:0]    id_q;
  logic [IRQ_ID_W-1:0]    rr_ptr;
  logic                   claim;
  irq_state_e             state_q;
  irq_state_e             state_d;

  ext_irq_sync #(.W(IRQ_NUM)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (irq_src_i),
    .sync_o (src_sync),
    .rise_o (src_rise)
  );

  assign claim    = (state_q == REQ) && core_ex_trap_ready_i;
  assign set_v    = (irq_edge_i & src_rise) | (~irq_edge_i & src_sync);
  assign clr_v    = claim ? (IRQ_NUM'(1) << id_q) : '0;
  assign elig     = pend_q & irq_en_i;
  assign elig_ext = IRQ_NUM_MAX'(elig);
  assign ptr_sel  = (RR_EN != 0) ? 5'(rr_ptr) : 5'd0;
  assign win5     = rr_winner(elig_ext, ptr_sel, IRQ_NUM);

  // Set is OR-ed in after the clear so an edge arriving in the claim cycle survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      id_q   <= '0;
      rr_ptr <= '0;
    end else begin
      pend_q <= (pend_q & ~clr_v) | set_v;
      if (state_q == IDLE && (|elig)) begin
        id_q <= win5[IRQ_ID_W-1:0];
      end
      if (claim && RR_EN != 0) begin
        rr_ptr <= (id_q == IRQ_ID_W'(IRQ_NUM - 1)) ? '0 : id_q + IRQ_ID_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|elig) state_d = REQ;
      REQ:     if (core_ex_trap_ready_i) state_d = SERVE;
      SERVE:   if (irq_cmpl_i && irq_cmpl_id_i == id_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_ex_trap_valid_o = (state_q == REQ);
    irq_busy_o           = (state_q == SERVE);
  end

  assign core_ex_trap_id_o = id_q;
  assign irq_pending_o     = pend_q;

endmodule

// File: doc/ext_irq_arbiter.md
Name: ext_irq_arbiter

Overview:
- Multi-source external interrupt controller.
- Collects up to IRQ_NUM asynchronous interrupt lines (GPIO/FPIOA pins, SD, timers), synchronises and latches them, and arbitrates among the enabled pending sources.
- Presents a single request to the core on the core_ex_trap_valid/core_ex_trap_ready handshake.
- Holds the claimed source in service until software signals completion through a CSR-driven complete pulse.
- Sits in sparrow_soc between the peripheral interrupt lines and the core external-trap input.

Parameters:
- IRQ_NUM, 8, number of interrupt sources (2..32).
- IRQ_ID_W, 3, width of source ID; equals $clog2(IRQ_NUM).
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority (lowest ID wins).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- irq_src_i  in  IRQ_NUM  raw interrupt lines, asynchronous to clk.
- irq_en_i  in  IRQ_NUM  per-source enable from CSR.
- irq_edge_i  in  IRQ_NUM  per-source mode: 1 = rising-edge, 0 = level-high.
- core_ex_trap_valid_o  out  1  interrupt request to core.
- core_ex_trap_ready_i  in  1  core accepts request.
- core_ex_trap_id_o  out  IRQ_ID_W  ID of requested/in-service source.
- irq_cmpl_i  in  1  one-cycle completion pulse from CSR write.
- irq_cmpl_id_i  in  IRQ_ID_W  ID being completed.
- irq_pending_o  out  IRQ_NUM  pending vector, readable by CSR.
- irq_busy_o  out  1  a source is in service.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All flops clear on reset.
- Reset values: core_ex_trap_valid_o=0, core_ex_trap_id_o=0, irq_pending_o=0, irq_busy_o=0, FSM=IDLE, RR pointer=0, synchroniser flops=0.
- Synchroniser: each irq_src_i passes through a 2-flop synchroniser. An edge-detect flop holds the previous synced value.
- Pending, edge mode: set on a synced 0->1 transition.
- Pending, level mode: set every cycle the synced value is 1.
- Pending clear: cleared when that source is claimed (valid&&ready).
- Simultaneous set and clear on the same source in one cycle: set wins, so a new edge is never lost.
- Pending latches regardless of irq_en_i. The enable gates arbitration only.
- Eligible vector = pending & irq_en_i.
- Latency: a source high at clk edge k gives a pending bit registered at edge k+2 and core_ex_trap_valid_o=1 after edge k+3 when the FSM is IDLE and nothing else competes. Zero-latency bypass is forbidden.
- FSM state IDLE: if eligible != 0, register the winner into core_ex_trap_id_o and go to REQ. Otherwise stay.
- FSM state REQ: valid_o=1. core_ex_trap_id_o is stable. Valid is never withdrawn, even if the source's enable drops or a higher-priority source appears. On ready=1: clear pending[id], irq_busy_o=1, go to SERVE. With RR_EN=1, the RR pointer becomes (id+1) mod IRQ_NUM.
- FSM state SERVE: valid_o=0. core_ex_trap_id_o holds the served ID. On irq_cmpl_i=1 with irq_cmpl_id_i==id: irq_busy_o=0, go to IDLE. A mismatched completion ID is ignored. No arbitration occurs in SERVE; sources keep latching pending.
- Round-robin: the search starts at the RR pointer and wraps modulo IRQ_NUM. The first eligible bit wins.
- Fixed priority: the lowest eligible ID wins.
- Completion in the same cycle as the IDLE->REQ decision: irq_cmpl_i is ignored outside SERVE.
- Level source still high after completion: it re-pends and is re-requested from the IDLE arbitration.
- Reset mid-handshake (REQ or SERVE): returns to IDLE with valid low. Pending state is lost.

Decomposition:
- Package ext_irq_pkg holds:
  - FSM enum (IDLE, REQ, SERVE);
  - IRQ_NUM_MAX=32;
  - a function computing the round-robin winner from eligible vector and pointer.
- One sub-module, ext_irq_sync: a per-bit 2-flop synchroniser plus edge detect, instantiated IRQ_NUM wide.

Test Plan:
1. Edge source 2, enabled. Raise irq_src_i[2] at edge k -> valid_o=1 after edge k+3, id_o=2. Ready at k+5 -> pending[2]=0, busy=1. Then irq_cmpl_i with id 2 -> busy=0, FSM IDLE.
2. RR_EN=1, sources 1 and 5 pending together, pointer=0 -> grant 1 first. After completion -> grant 5, pointer=6. Re-pend 1 and 5 -> grant 1 (wrap).
3. RR_EN=0, sources 3 and 6 pending -> grant 3. Then 6.
4. Source 4 disabled with pending set -> no valid. Enable at cycle n -> valid_o after edge n+1, id_o=4.
5. In REQ for id 1, drop irq_en_i[1] and raise source 0 -> valid_o and id_o=1 held until ready. Completion with id 3 in SERVE -> ignored, busy stays 1.
6. Level source 7 held high across completion -> re-requested. New edge on edge-mode source 2 in the claim cycle -> pending[2] stays 1. Assert rst_n=0 in SERVE -> valid_o=0, busy=0, pending=0 immediately.
